// File: rtl/ysyx_22041207_mem_responder.sv
// ysyx_22041207_mem_responder: fixed-latency single-outstanding memory responder (YSYX_22041207_MEM_RAND_DELAY_EN adds LFSR jitter)
module ysyx_22041207_mem_responder #(
  parameter logic [63:0] BASE = 64'h8000_0000,
  parameter int DEPTH_LOG2 = 12,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [63:0] req_addr,
  input  logic        req_wen,
  input  logic [63:0] req_wdata,
  input  logic [7:0]  req_wmask,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err
);
  localparam int WORDS = 1 << DEPTH_LOG2;
  localparam logic [64:0] LIM = {1'b0, BASE} + (65'd8 << DEPTH_LOG2);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state;
  logic [4:0] cnt;
  logic [4:0] wait_n;
  logic [63:0] a_addr, a_wdata;
  logic a_wen;
  logic [7:0] a_wmask;
  logic [63:0] mem [0:WORDS-1];
  logic [63:0] cur_addr, cur_wdata;
  logic cur_wen, hit, accept, enter_resp;
  logic [7:0] cur_wmask;
  logic [DEPTH_LOG2-1:0] idx;
`ifdef YSYX_22041207_MEM_RAND_DELAY_EN
  logic [7:0] lfsr;
  // free-running jitter source, taps 8,6,5,4
  always_ff @(posedge clk)
    lfsr <= rst ? 8'hA5 : {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  assign wait_n = 5'(LATENCY - 1) + {2'b0, lfsr[2:0]};
`else
  assign wait_n = 5'(LATENCY - 1);
`endif
  // with zero wait cycles the access happens on the accept edge, so use the live request then
  always_comb begin
    cur_addr   = state == IDLE ? req_addr : a_addr;
    cur_wen    = state == IDLE ? req_wen : a_wen;
    cur_wdata  = state == IDLE ? req_wdata : a_wdata;
    cur_wmask  = state == IDLE ? req_wmask : a_wmask;
    hit        = cur_addr >= BASE && {1'b0, cur_addr} < LIM;
    idx        = DEPTH_LOG2'((cur_addr - BASE) >> 3);
    accept     = state == IDLE && req_valid && req_ready;
    enter_resp = (accept && wait_n == 5'd0) || (state == WAIT && cnt == 5'd1);
  end
  // byte-masked commit on the edge entering RESP; reset suppresses it and never clears the array
  always_ff @(posedge clk)
    if (!rst && enter_resp && cur_wen && hit)
      for (int i = 0; i < 8; i++)
        if (cur_wmask[i]) mem[idx][8*i +: 8] <= cur_wdata[8*i +: 8];
  // request/response handshake FSM with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
    end else begin
      if (accept) begin
        a_addr    <= req_addr;
        a_wen     <= req_wen;
        a_wdata   <= req_wdata;
        a_wmask   <= req_wmask;
        req_ready <= 1'b0;
        state     <= WAIT;
        cnt       <= wait_n;
      end
      if (state == WAIT) cnt <= cnt - 5'd1;
      if (enter_resp) begin
        state      <= RESP;
        resp_valid <= 1'b1;
        resp_err   <= !hit;
        resp_rdata <= (cur_wen || !hit) ? 64'd0 : mem[idx];
      end
      if (state == RESP && resp_ready) begin
        state      <= IDLE;
        resp_valid <= 1'b0;
        req_ready  <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_ysyx_22041207_mem_responder.sv
// tb_ysyx_22041207_mem_responder: directed plus randomized checks against a word-array model
module tb_ysyx_22041207_mem_responder;
  localparam logic [63:0] BASE = 64'h8000_0000;
  localparam logic [63:0] SPAN = 64'd32768;
  logic clk = 0, rst = 1;
  logic req_valid = 0, req_ready, req_wen = 0, resp_valid, resp_ready = 0, resp_err;
  logic [63:0] req_addr = 0, req_wdata = 0, resp_rdata;
  logic [7:0] req_wmask = 0;
  int errors = 0, checks = 0, lat;
  logic [63:0] rd;
  logic [63:0] model [int];

  ysyx_22041207_mem_responder dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_wen(req_wen), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic in_win(input logic [63:0] a);
    return a >= BASE && a < BASE + SPAN;
  endfunction

  function automatic logic [63:0] r64();
    return {$urandom, $urandom};
  endfunction

  task automatic op(input logic [63:0] addr, input logic wen, input logic [63:0] wd,
                    input logic [7:0] wm, input int bp, output int l, output logic [63:0] got);
    logic [63:0] exp_rd, m;
    logic exp_err;
    int w;
    exp_err = !in_win(addr);
    w = int'((addr - BASE) >> 3);
    exp_rd = 0;
    if (!exp_err) begin
      if (wen) begin
        m = model.exists(w) ? model[w] : 64'd0;
        for (int b = 0; b < 8; b++) if (wm[b]) m[8*b +: 8] = wd[8*b +: 8];
        model[w] = m;
      end else exp_rd = model[w];
    end
    @(negedge clk);
    chk("ready_idle", {63'd0, req_ready}, 64'd1);
    req_valid = 1; req_addr = addr; req_wen = wen; req_wdata = wd; req_wmask = wm;
    @(posedge clk);
    #1 req_valid = 0; req_addr = r64(); req_wen = 1'($urandom); req_wdata = r64(); req_wmask = 8'($urandom);
    l = 1;
    @(negedge clk);
    while (!resp_valid && l < 40) begin
      l++;
      @(negedge clk);
    end
    got = resp_rdata;
    chk("resp_valid", {63'd0, resp_valid}, 64'd1);
`ifdef YSYX_22041207_MEM_RAND_DELAY_EN
    chk("latency_range", {63'd0, l >= 2 && l <= 9}, 64'd1);
`else
    chk("latency", 64'(l), 64'd2);
`endif
    chk("resp_err", {63'd0, resp_err}, {63'd0, exp_err});
    chk("resp_rdata", resp_rdata, exp_rd);
    chk("ready_busy", {63'd0, req_ready}, 64'd0);
    repeat (bp) begin
      @(negedge clk);
      chk("hold_valid", {63'd0, resp_valid}, 64'd1);
      chk("hold_rdata", resp_rdata, exp_rd);
      chk("hold_ready", {63'd0, req_ready}, 64'd0);
    end
    resp_ready = 1;
    @(posedge clk);
    #1 resp_ready = 0;
    @(negedge clk);
    chk("post_valid", {63'd0, resp_valid}, 64'd0);
    chk("post_ready", {63'd0, req_ready}, 64'd1);
  endtask

  initial begin
    logic [63:0] a;
    int lats [int];
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_valid", {63'd0, resp_valid}, 64'd0);
    chk("rst_err", {63'd0, resp_err}, 64'd0);
    chk("rst_rdata", resp_rdata, 64'd0);
    chk("rst_ready", {63'd0, req_ready}, 64'd1);
    for (int i = 0; i < 16; i++) op(BASE + 64'(8 * i), 1, r64(), 8'hFF, 0, lat, rd);
    op(64'h8000_0010, 1, 64'h1122334455667788, 8'hFF, 0, lat, rd);
    chk("write_rdata", rd, 64'd0);
    op(64'h8000_0010, 0, 0, 0, 0, lat, rd);
    chk("read_back", rd, 64'h1122334455667788);
    op(64'h8000_0010, 1, 64'hAAAAAAAA_BBBBBBBB, 8'h0F, 0, lat, rd);
    op(64'h8000_0010, 0, 0, 0, 0, lat, rd);
    chk("partial", rd, 64'h11223344_BBBBBBBB);
    op(64'h7FFF_FFF8, 0, 0, 0, 0, lat, rd);
    op(64'h8000_8000, 1, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0, lat, rd);
    op(64'h8000_0000, 0, 0, 0, 0, lat, rd);
    op(64'h8000_0010, 1, 64'h0, 8'h00, 0, lat, rd);
    op(64'h8000_0010, 0, 0, 0, 5, lat, rd);
    chk("nomask_bp", rd, 64'h11223344_BBBBBBBB);
    op(64'h8000_7FF8, 1, 64'h0123456789ABCDEF, 8'hFF, 0, lat, rd);
    op(64'h8000_7FF8, 0, 0, 0, 1, lat, rd);
    op(64'hFFFF_FFFF_FFFF_FFF8, 0, 0, 0, 0, lat, rd);
    @(negedge clk);
    req_valid = 1; req_addr = BASE; req_wen = 1; req_wdata = 64'hDEAD; req_wmask = 8'hFF;
    @(posedge clk);
    #1 req_valid = 0;
    @(negedge clk);
    chk("wait_valid", {63'd0, resp_valid}, 64'd0);
    rst = 1;
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rstw_valid", {63'd0, resp_valid}, 64'd0);
    chk("rstw_ready", {63'd0, req_ready}, 64'd1);
    op(BASE, 0, 0, 0, 0, lat, rd);
    @(negedge clk);
    req_valid = 1; req_addr = BASE + 8; req_wen = 0;
    @(posedge clk);
    #1 req_valid = 0;
    repeat (12) @(negedge clk);
    chk("resp_hold_valid", {63'd0, resp_valid}, 64'd1);
    rst = 1;
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rstr_valid", {63'd0, resp_valid}, 64'd0);
    chk("rstr_ready", {63'd0, req_ready}, 64'd1);
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 7))
        6: a = BASE - 64'(8 * $urandom_range(1, 4));
        7: a = $urandom_range(0, 1) ? BASE + SPAN + 64'(8 * $urandom_range(0, 3)) : 64'hFFFF_FFFF_FFFF_FFF8;
        default: a = BASE + 64'(8 * $urandom_range(0, 15));
      endcase
      a[2:0] = 3'($urandom);
      op(a, 1'($urandom), r64(), $urandom_range(0, 3) == 0 ? 8'h00 : 8'($urandom), $urandom_range(0, 3), lat, rd);
    end
`ifdef YSYX_22041207_MEM_RAND_DELAY_EN
    for (int i = 0; i < 16; i++) begin
      op(BASE + 64'(8 * (i % 16)), 0, 0, 0, 0, lat, rd);
      lats[lat] = 1;
    end
    chk("distinct_lat", {63'd0, lats.num() >= 2}, 64'd1);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ysyx_22041207_mem_responder.md
YSYX_22041207_MEM_RESPONDER -- requirements
Module: ysyx_22041207_mem_responder

Interface
REQ-001 SHALL have parameter BASE, default 64'h8000_0000, first byte address of the memory window.
REQ-002 SHALL have parameter DEPTH_LOG2, default 12, giving 2^DEPTH_LOG2 64-bit words.
REQ-003 SHALL have parameter LATENCY, default 2, cycles from accept to response; legal range 1..15.
REQ-004 SHALL have these ports:
- clk  input  1  sole clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  initiator presents a request.
- req_ready  output  1  responder can accept a request.
- req_addr  input  64  byte address; bits [2:0] ignored.
- req_wen  input  1  1 = write, 0 = read.
- req_wdata  input  64  write data, lane-aligned.
- req_wmask  input  8  byte-lane write enables.
- resp_valid  output  1  response present.
- resp_ready  input  1  initiator accepts the response.
- resp_rdata  output  64  aligned read word; 0 for writes and errors.
- resp_err  output  1  address outside the window.

Function
REQ-005 SHALL use the states IDLE, WAIT and RESP, with at most one request outstanding.
REQ-006 SHALL drive req_ready=1 only in IDLE; a request is accepted on an edge where req_valid && req_ready.
REQ-007 SHALL latch addr, wen, wdata and wmask at accept; later changes on the req_* inputs SHALL have no effect.
REQ-008 On accept with LATENCY=1, SHALL go directly to RESP; otherwise SHALL go to WAIT with counter=LATENCY-1.
REQ-009 In WAIT, SHALL decrement the counter each cycle and go to RESP on the edge where the counter equals 1.
REQ-010 SHALL raise resp_valid exactly LATENCY cycles after the accept edge (fixed-latency build).
REQ-011 In RESP, SHALL hold resp_valid, resp_rdata and resp_err stable until resp_valid && resp_ready, then return to IDLE; req_ready rises on the following cycle (no same-cycle re-accept).
REQ-012 Word index SHALL be (addr - BASE)[DEPTH_LOG2+2:3].
REQ-013 In-window SHALL mean BASE <= addr < BASE + 8*2^DEPTH_LOG2, using an unsigned 64-bit compare with no wrap-around.
REQ-014 A write SHALL commit to the array on the edge entering RESP, updating only the bytes whose wmask bit is 1.
- wmask=0 SHALL be a legal no-op write that is still acknowledged.
REQ-015 A read SHALL sample the array on the edge entering RESP, returning the full 64-bit word; byte extraction and sign-extension belong to the initiator.
REQ-016 An out-of-window request SHALL respond with resp_err=1 and resp_rdata=0, and SHALL NOT modify the array.
REQ-017 A read issued after a completed write to the same word SHALL return the updated data.
REQ-018 Outputs SHALL be registered; there SHALL be no combinational path from req_* or resp_ready to any output.

Reset
REQ-019 While rst=1 on an edge, the block SHALL:
- enter IDLE;
- set req_ready=1 on the following cycle;
- set resp_valid=0, resp_err=0, resp_rdata=0 and counter=0.
REQ-020 Reset during WAIT SHALL discard the pending request, and an uncommitted write SHALL NOT reach the array.
REQ-021 Reset during RESP SHALL drop resp_valid without a handshake.
REQ-022 Reset SHALL NOT clear the array contents.

Configuration
REQ-023 With YSYX_22041207_MEM_RAND_DELAY_EN defined:
- an 8-bit Fibonacci LFSR (taps 8,6,5,4) SHALL be seeded 8'hA5 on reset and SHALL advance every cycle;
- at accept, lfsr[2:0] (0..7) SHALL be added to the WAIT count, so latency = LATENCY + lfsr[2:0].
REQ-024 Without YSYX_22041207_MEM_RAND_DELAY_EN, latency SHALL be exactly LATENCY and no LFSR SHALL exist.

Verification (fixed-latency build, LATENCY=2, unless noted)
REQ-025 Write, then read:
- write addr 0x8000_0010, wdata 0x1122334455667788, wmask 0xFF -> resp_valid at accept+2, rdata=0, err=0;
- read of 0x8000_0010 -> rdata=0x1122334455667788.
REQ-026 Partial write: wmask 0x0F, wdata 0xAAAAAAAA_BBBBBBBB to the same word -> read returns 0x11223344_BBBBBBBB.
REQ-027 Out of window: read addr 0x7FFF_FFF8, then write to addr 0x8000_8000 (DEPTH_LOG2=12) -> each returns err=1, rdata=0, and the array is unchanged.
REQ-028 Backpressure: resp_ready held 0 for 5 cycles -> resp_valid and resp_rdata stay stable and req_ready=0; the handshake completes on the cycle resp_ready=1.
REQ-029 Reset mid-WAIT on a write of 0xDEAD to 0x8000_0000 -> a later read returns the prior value; resp_valid=0 and req_ready=1 after reset.
REQ-030 RAND_DELAY build: 16 back-to-back reads -> every latency lies in 2..9 and at least two distinct latencies are seen.
